aes_key_expand: RTL and testbench

- Parametrised AES key-expansion engine; successor to the fixed AES-128 single-round key schedule.
- Supports AES-128, AES-192 and AES-256 through one parameter.
- Generates the whole round-key sequence 0..Nr from one start pulse, one 32-bit word per cycle.
- Streams 128-bit round keys to the cipher datapath over a valid/ready handshake, with backpressure stalling generation.

---
 rtl/aes_key_expand.sv | 155 +++++++++++++++
 tb/tb_aes_key_expand.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
`timescale 1ns/1ps
// aes_key_expand: AES-128/192/256 key-schedule engine. One start pulse
// generates every round key 0..Nr, one 32-bit word per cycle, and streams
// each 128-bit round key out over a valid/ready handshake. A round key that
// has not been taken yet stalls further word generation.
module aes_key_expand #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [3:0]          rk_index,
  output logic                done
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [5:0] LAST_W = 6'(NW - 1);
  localparam logic [2:0] MOD_LAST = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expand: KEY_BITS must be 128, 192 or 256");
  end

  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DRAIN} state_t;

  state_t       r_state, w_state_nxt;
  logic [31:0]  r_win [NK];   // r_win[0] = w[i-Nk] ... r_win[NK-1] = w[i-1]
  logic [31:0]  r_asm [4];
  logic [5:0]   r_cnt;        // word index i
  logic [2:0]   r_mod;        // i mod Nk
  logic [7:0]   r_rcon;
  logic         r_rk_valid;
  logic [127:0] r_rk_data;
  logic [3:0]   r_rk_index;
  logic         r_done;

  logic        w_slot3, w_go, w_xfer;
  logic [31:0] w_prev, w_old, w_sub_in, w_sub, w_word;
  logic [7:0]  w_rcon_nxt;

  assign w_slot3 = (r_cnt[1:0] == 2'd3);
  // A slot-3 word may only be generated when the output register is free or
  // being emptied this cycle; slots 0-2 never wait.
  assign w_go    = (r_state == S_EXPAND) && (!w_slot3 || !r_rk_valid || rk_ready);
  assign w_xfer  = r_rk_valid && rk_ready;
  assign w_prev  = r_win[NK-1];
  assign w_old   = r_win[0];
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // Next key-schedule word from the sliding window.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = sub_word(w_sub_in);
    w_word   = w_old ^ w_prev;
    if (r_cnt < NK_W) begin
      w_word = r_win[0];  // window rotates, so the oldest entry is key word i
    end else if (r_mod == 3'd0) begin
      w_word = w_old ^ w_sub ^ {r_rcon, 24'h0};
    end else if (NK == 8 && r_mod == 3'd4) begin
      w_word = w_old ^ w_sub;
    end
  end

  // Next-state logic of the control FSM.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_EXPAND;
      S_EXPAND: if (w_go && r_cnt == LAST_W) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_xfer) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Word generation, window, Rcon and round-key output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: window and assembly slots are plain flops, cleared so no key survives an abort.
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
      for (int j = 0; j < 4; j++)  r_asm[j] <= '0;
      r_cnt      <= '0;
      r_mod      <= '0;
      r_rcon     <= '0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= '0;
      r_rk_index <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && w_xfer;
      if (r_state == S_IDLE && start) begin
        for (int j = 0; j < NK; j++) r_win[j] <= key_in[KEY_BITS-1-32*j -: 32];
        r_cnt  <= '0;
        r_mod  <= '0;
        r_rcon <= 8'h01;
      end else if (w_go) begin
        for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
        r_win[NK-1]       <= w_word;
        r_asm[r_cnt[1:0]] <= w_word;
        r_cnt <= r_cnt + 6'd1;
        r_mod <= (r_mod == MOD_LAST) ? 3'd0 : r_mod + 3'd1;
        if (r_cnt >= NK_W && r_mod == 3'd0) r_rcon <= w_rcon_nxt;
      end
      if (w_go && w_slot3) begin
        r_rk_data  <= {r_asm[0], r_asm[1], r_asm[2], w_word};
        r_rk_index <= r_cnt[5:2];
        r_rk_valid <= 1'b1;
      end else if (w_xfer) begin
        r_rk_valid <= 1'b0;
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign rk_valid = r_rk_valid;
  assign rk_data  = r_rk_data;
  assign rk_index = r_rk_index;
  assign done     = r_done;

endmodule

// File: tb/tb_aes_key_expand.sv
`timescale 1ns/1ps
// Bench for aes_key_expand: one instance per key size, a scoreboard queue of
// expected round keys filled at start time and drained by a monitor on each
// handshake, plus per-scenario tasks with their own inline checks.
module tb_aes_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   start;
  logic         rk_ready = 1'b1;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [2:0]   busy, rk_valid, done;
  logic [127:0] rk_data  [3];
  logic [3:0]   rk_index [3];

  aes_key_expand #(.KEY_BITS(128)) u_aes128 (
    .clk(clk), .rst(rst), .start(start[0]), .key_in(key128), .busy(busy[0]),
    .rk_valid(rk_valid[0]), .rk_ready(rk_ready), .rk_data(rk_data[0]),
    .rk_index(rk_index[0]), .done(done[0]));

  aes_key_expand #(.KEY_BITS(192)) u_aes192 (
    .clk(clk), .rst(rst), .start(start[1]), .key_in(key192), .busy(busy[1]),
    .rk_valid(rk_valid[1]), .rk_ready(rk_ready), .rk_data(rk_data[1]),
    .rk_index(rk_index[1]), .done(done[1]));

  aes_key_expand #(.KEY_BITS(256)) u_aes256 (
    .clk(clk), .rst(rst), .start(start[2]), .key_in(key256), .busy(busy[2]),
    .rk_valid(rk_valid[2]), .rk_ready(rk_ready), .rk_data(rk_data[2]),
    .rk_index(rk_index[2]), .done(done[2]));

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  typedef struct {
    int           tag;
    logic [3:0]   idx;
    logic [127:0] data;
    logic [127:0] mask;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int ready_pct = 100;
  int done_cnt [3];
  int stall_cnt = 0;

  task automatic push(input int tag, input int idx, input logic [127:0] data,
                      input logic [127:0] mask);
    sb_item_t e;
    e.tag = tag; e.idx = 4'(idx); e.data = data; e.mask = mask;
    sb_q.push_back(e);
  endtask

  task automatic push_aes128();
    for (int r = 0; r < 11; r++) push(0, r, RK128[r], '1);
  endtask

  task automatic pulse_start(input int k);
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
  endtask

  // Edges since acceptance until done is seen; -1 when the budget runs out.
  task automatic wait_done(input int k, input int budget, output int cycles);
    cycles = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done[k] === 1'b1) begin cycles = n; break; end
    end
  endtask

  // rk_ready driver: changes just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    rk_ready = (ready_pct >= 100) || (int'($urandom_range(0, 99)) < ready_pct);
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    sb_item_t     e;
    logic [127:0] pd [3];
    logic [3:0]   pi [3];
    bit           ps [3];
    for (int k = 0; k < 3; k++) ps[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst !== 1'b1) begin
          ps[k] = 1'b0;
        end else begin
          if (done[k] === 1'b1) done_cnt[k]++;
          if (ps[k]) begin
            n_checks++;
            if (rk_valid[k] !== 1'b1 || rk_data[k] !== pd[k] || rk_index[k] !== pi[k]) begin
              n_errors++;
              $display("FAIL stall_hold[%0d]: got v=%b idx=%0d data=%h, required v=1 idx=%0d data=%h",
                       k, rk_valid[k], rk_index[k], rk_data[k], pi[k], pd[k]);
            end
          end
          if (rk_valid[k] === 1'b1 && rk_ready === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
              n_errors++;
              $display("FAIL unexpected_key[%0d]: got idx=%0d data=%h, required no transfer",
                       k, rk_index[k], rk_data[k]);
            end else begin
              e = sb_q.pop_front();
              if (e.tag !== k || rk_index[k] !== e.idx ||
                  (rk_data[k] & e.mask) !== (e.data & e.mask)) begin
                n_errors++;
                $display("FAIL round_key[%0d]: got idx=%0d data=%h, required inst=%0d idx=%0d data=%h mask=%h",
                         k, rk_index[k], rk_data[k], e.tag, e.idx, e.data, e.mask);
              end
            end
          end
          ps[k] = (rk_valid[k] === 1'b1 && rk_ready !== 1'b1);
          if (ps[k]) stall_cnt++;
          pd[k] = rk_data[k];
          pi[k] = rk_index[k];
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; start = '0;
    key128 = K128;
    key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (busy[k] !== 1'b0 || rk_valid[k] !== 1'b0 || rk_data[k] !== '0 ||
          rk_index[k] !== '0 || done[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: got busy=%b v=%b idx=%0d data=%h done=%b, required all 0",
                 k, busy[k], rk_valid[k], rk_index[k], rk_data[k], done[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_aes128();
    int first_v = -1, v10_at = -1, done_at = -1;
    bit busy_ok = 1'b0;
    ready_pct = 100; done_cnt[0] = 0;
    push_aes128();
    pulse_start(0);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0) busy_ok = (busy[0] === 1'b1);
      if (first_v < 0 && rk_valid[0] === 1'b1) first_v = n;
      if (v10_at < 0 && rk_valid[0] === 1'b1 && rk_index[0] === 4'd10) v10_at = n;
      if (done[0] === 1'b1) begin done_at = n; break; end
    end
    n_checks++;
    if (!busy_ok) begin n_errors++; $display("FAIL aes128_busy: busy not 1 after start, required 1"); end
    n_checks++;
    if (first_v !== 4) begin n_errors++; $display("FAIL aes128_rk0_latency: got %0d, required 4", first_v); end
    n_checks++;
    if (v10_at !== 44) begin n_errors++; $display("FAIL aes128_rk10_latency: got %0d, required 44", v10_at); end
    n_checks++;
    if (done_at !== 45) begin n_errors++; $display("FAIL aes128_done_latency: got %0d, required 45", done_at); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt[0] !== 1 || busy[0] !== 1'b0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL aes128_end: got done_cnt=%0d busy=%b pending=%0d, required 1 0 0",
               done_cnt[0], busy[0], sb_q.size());
    end
  endtask

  task automatic test_aes192();
    int c;
    done_cnt[1] = 0;
    push(1, 0, key192[191:64], '1);
    push(1, 1, {64'h62f8ead2522c6b7b, 32'hfe0c91f7, 32'h0}, {{96{1'b1}}, 32'h0});
    for (int r = 2; r < 12; r++) push(1, r, '0, '0);
    push(1, 12, 128'he98ba06f448c773c8ecc720401002202, '1);
    pulse_start(1);
    wait_done(1, 300, c);
    n_checks++;
    if (c !== 53) begin n_errors++; $display("FAIL aes192_done_latency: got %0d, required 53", c); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt[1] !== 1 || busy[1] !== 1'b0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL aes192_end: got done_cnt=%0d busy=%b pending=%0d, required 1 0 0",
               done_cnt[1], busy[1], sb_q.size());
    end
  endtask

  task automatic test_aes256();
    int c;
    done_cnt[2] = 0;
    push(2, 0, key256[255:128], '1);
    push(2, 1, key256[127:0], '1);
    push(2, 2, {32'h9ba35411, 96'h0}, {{32{1'b1}}, 96'h0});
    for (int r = 3; r < 14; r++) push(2, r, '0, '0);
    push(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, '1);
    pulse_start(2);
    wait_done(2, 300, c);
    n_checks++;
    if (c !== 61) begin n_errors++; $display("FAIL aes256_done_latency: got %0d, required 61", c); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt[2] !== 1 || busy[2] !== 1'b0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL aes256_end: got done_cnt=%0d busy=%b pending=%0d, required 1 0 0",
               done_cnt[2], busy[2], sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    int c;
    done_cnt[0] = 0; stall_cnt = 0;
    ready_pct = 30;
    push_aes128();
    pulse_start(0);
    wait_done(0, 3000, c);
    ready_pct = 100;
    n_checks++;
    if (c < 0) begin n_errors++; $display("FAIL bp_timeout: done not seen in 3000 cycles, required done"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt[0] !== 1 || sb_q.size() != 0 || stall_cnt == 0) begin
      n_errors++;
      $display("FAIL bp_end: got done_cnt=%0d pending=%0d stalls=%0d, required 1 0 >0",
               done_cnt[0], sb_q.size(), stall_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int c;
    done_cnt[0] = 0;
    key128 = K128;
    push_aes128();
    pulse_start(0);
    repeat (10) @(posedge clk);
    key128 = K128B;
    pulse_start(0);
    wait_done(0, 200, c);
    n_checks++;
    if (c < 0) begin n_errors++; $display("FAIL ignore_timeout: done not seen in 200 cycles, required done"); end
    repeat (6) @(negedge clk);
    n_checks++;
    if (done_cnt[0] !== 1 || busy[0] !== 1'b0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL ignore_end: got done_cnt=%0d busy=%b pending=%0d, required 1 0 0",
               done_cnt[0], busy[0], sb_q.size());
    end
    key128 = K128;
  endtask

  task automatic test_reset_abort();
    int c;
    push_aes128();
    pulse_start(0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (busy[0] !== 1'b0 || rk_valid[0] !== 1'b0 || rk_data[0] !== '0 ||
        rk_index[0] !== '0 || done[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_reset: got busy=%b v=%b idx=%0d data=%h done=%b, required all 0",
               busy[0], rk_valid[0], rk_index[0], rk_data[0], done[0]);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    done_cnt[0] = 0;
    push_aes128();
    pulse_start(0);
    wait_done(0, 200, c);
    n_checks++;
    if (c !== 45) begin n_errors++; $display("FAIL restart_done_latency: got %0d, required 45", c); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt[0] !== 1 || busy[0] !== 1'b0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL restart_end: got done_cnt=%0d busy=%b pending=%0d, required 1 0 0",
               done_cnt[0], busy[0], sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_start_ignored();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
